// File: rtl/fc_sink_pkg.sv
// fc_sink_pkg: shared state encoding, index-width helper and default element width
package fc_sink_pkg;
  typedef enum logic [0:0] {COLLECT = 1'b0, REPORT = 1'b1} state_t;
  localparam int T_DEFAULT = 16;
  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/fc_sink_counter.sv
// fc_sink_counter: modulo-M element counter with last-element flag
module fc_sink_counter #(
  parameter int M    = 6,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_incr,
  output logic [IDXW-1:0] o_cnt,
  output logic            o_last
);
  logic [IDXW-1:0] r_cnt;
  assign o_last = (r_cnt == IDXW'(M - 1));
  assign o_cnt  = r_cnt;
  // advance on every accepted element, wrapping after the M-th
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (i_incr) r_cnt <= o_last ? '0 : r_cnt + IDXW'(1);
  end
endmodule

// File: rtl/fc_argmax_sink.sv
// fc_argmax_sink: argmax over an M-element stream; FC_ARGMAX_STORE_EN adds a readable element store
module fc_argmax_sink
  import fc_sink_pkg::*;
#(
  parameter int M    = 6,
  parameter int T    = T_DEFAULT,
  parameter int IDXW = idx_width(M)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [T-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDXW-1:0]     out_index,
  output logic signed [T-1:0] out_value
`ifdef FC_ARGMAX_STORE_EN
  ,
  input  logic [IDXW-1:0]     rd_addr,
  output logic [T-1:0]        rd_data
`endif
);
  state_t              r_state;
  logic signed [T-1:0] r_max_val;
  logic [IDXW-1:0]     r_max_idx;
  logic                w_accept, w_last, w_take;
  logic [IDXW-1:0]     w_cnt;
  logic signed [T-1:0] w_win_val;
  logic [IDXW-1:0]     w_win_idx;

  assign in_ready  = (r_state == COLLECT);
  assign w_accept  = in_valid && in_ready;
  // first element always seeds the maximum; later ones must be strictly greater so ties keep the earliest index
  assign w_take    = (w_cnt == '0) || (in_data > r_max_val);
  assign w_win_val = w_take ? in_data : r_max_val;
  assign w_win_idx = w_take ? w_cnt : r_max_idx;

  fc_sink_counter #(.M(M), .IDXW(IDXW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .i_incr(w_accept),
    .o_cnt (w_cnt),
    .o_last(w_last)
  );

  // running maximum, result registers and COLLECT/REPORT state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= COLLECT;
      r_max_val <= '0;
      r_max_idx <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_value <= '0;
    end else if (w_accept) begin
      r_max_val <= w_win_val;
      r_max_idx <= w_win_idx;
      if (w_last) begin
        out_index <= w_win_idx;
        out_value <= w_win_val;
        out_valid <= 1'b1;
        r_state   <= REPORT;
      end
    end else if (r_state == REPORT && out_ready) begin
      out_valid <= 1'b0;
      r_state   <= COLLECT;
    end
  end

`ifdef FC_ARGMAX_STORE_EN
  logic [T-1:0] r_mem [M];
  // element store, deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[w_cnt] <= in_data;
  end
  assign rd_data = (int'(rd_addr) < M) ? r_mem[rd_addr] : '0;
`endif
endmodule

// File: tb/tb_fc_argmax_sink.sv
// tb_fc_argmax_sink: table-driven, hand sequences and randomized checks against an argmax model
`timescale 1ns/1ps
module tb_fc_argmax_sink;
  logic               clk = 0;
  logic               reset = 1;
  logic               in_valid = 0;
  logic               in_ready;
  logic signed [15:0] in_data = 0;
  logic               out_valid;
  logic               out_ready = 0;
  logic [2:0]         out_index;
  logic signed [15:0] out_value;
`ifdef FC_ARGMAX_STORE_EN
  logic [2:0]         rd_addr = 0;
  logic [15:0]        rd_data;
`endif
  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [95:0]        d;
    logic [2:0]         idx;
    logic signed [15:0] val;
  } vec_t;
  vec_t tbl [7];

  fc_argmax_sink #(.M(6), .T(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_value(out_value)
`ifdef FC_ARGMAX_STORE_EN
    ,
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(int a, int b, int c, int e, int f, int g, int idx, int val);
    vec_t v;
    v.d   = {16'(g), 16'(f), 16'(e), 16'(c), 16'(b), 16'(a)};
    v.idx = 3'(idx);
    v.val = 16'(val);
    return v;
  endfunction

  function automatic void model(input logic [95:0] d, output int idx, output int val);
    int v;
    idx = 0;
    val = int'($signed(d[15:0]));
    for (int i = 1; i < 6; i++) begin
      v = int'($signed(d[i*16 +: 16]));
      if (v > val) begin
        val = v;
        idx = i;
      end
    end
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [95:0] d, input int n, input int gmax);
    int w;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gmax, 0)) cyc();
      in_valid = 1;
      in_data  = d[i*16 +: 16];
      w = 0;
      while (!in_ready && w < 50) begin
        cyc();
        w++;
      end
      if (w == 50) chk("send_timeout", 0, 1);
      cyc();
      in_valid = 0;
    end
  endtask

  task automatic collect(input string n, input int idx, input int val);
    chk({n, "_valid"}, int'(out_valid), 1);
    chk({n, "_index"}, int'(out_index), idx);
    chk({n, "_value"}, int'(out_value), val);
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk({n, "_valid_drop"}, int'(out_valid), 0);
    chk({n, "_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    logic [95:0] d;
    int ei, ev;
    tbl[0] = mk(5, -3, 12, 12, 0, 7, 2, 12);
    tbl[1] = mk(-5, -2, -9, -2, -100, -32768, 1, -2);
    tbl[2] = mk(-32768, -32768, -32768, -32768, -32768, -32768, 0, -32768);
    tbl[3] = mk(1, 2, 3, 4, 5, 100, 5, 100);
    tbl[4] = mk(10, -1, 3, 4, 5, 6, 0, 10);
    tbl[5] = mk(7, 7, 7, 7, 7, 8, 5, 8);
    tbl[6] = mk(-1, 32767, 0, 32767, -32768, 1, 1, 32767);

    repeat (2) cyc();
    reset = 0;
    cyc();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_out_value", int'(out_value), 0);

    for (int t = 0; t < 7; t++) begin
      send(tbl[t].d, 6, 0);
      collect($sformatf("tbl%0d", t), int'(tbl[t].idx), int'(tbl[t].val));
    end

    send(mk(3, 1, 4, 1, 5, 9, 0, 0).d, 6, 0);
    in_valid = 1;
    in_data  = 999;
    for (int k = 0; k < 10; k++) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_index", int'(out_index), 5);
      chk("hold_value", int'(out_value), 9);
      chk("hold_in_ready", int'(in_ready), 0);
      cyc();
    end
    in_valid = 0;
    collect("hold_release", 5, 9);
    send(mk(2, 20, 1, 1, 1, 1, 0, 0).d, 6, 0);
    collect("after_hold", 1, 20);

    for (int r = 0; r < 3; r++) begin
      send(mk(1, 2, 3, 4, 5, 100, 0, 0).d, 6, 3);
      collect($sformatf("gap%0d", r), 5, 100);
    end

    send(mk(50, 60, 70, 0, 0, 0, 0, 0).d, 3, 0);
    reset = 1;
    cyc();
    reset = 0;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    send(mk(9, 8, 7, 6, 5, 4, 0, 0).d, 6, 0);
    collect("midrst", 0, 9);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 6; i++)
        d[i*16 +: 16] = (r % 2 == 0) ? 16'($urandom_range(7, 0) - 4) : 16'($urandom);
      model(d, ei, ev);
      send(d, 6, $urandom_range(2, 0));
      repeat ($urandom_range(3, 0)) begin
        chk("rnd_wait_valid", int'(out_valid), 1);
        cyc();
      end
      collect($sformatf("rnd%0d", r), ei, ev);
    end

`ifdef FC_ARGMAX_STORE_EN
    d = mk(10, -1, 3, 4, 5, 6, 0, 0).d;
    send(d, 6, 0);
    for (int a = 0; a < 6; a++) begin
      rd_addr = 3'(a);
      #1;
      chk($sformatf("store%0d", a), int'(rd_data), int'(d[a*16 +: 16]));
    end
    rd_addr = 7;
    #1;
    chk("store_oob", int'(rd_data), 0);
    collect("store", 0, 10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
